// File: rtl/soc_timer_pkg.sv
// Shared definitions for the interval-timer host: register map, control/status bit
// positions and the host sequencer state encoding.
package soc_timer_pkg;

    typedef logic [2:0] tmr_addr_t;

    localparam tmr_addr_t TMR_STATUS  = 3'd0;
    localparam tmr_addr_t TMR_CONTROL = 3'd1;
    localparam tmr_addr_t TMR_PER_L   = 3'd2;
    localparam tmr_addr_t TMR_PER_H   = 3'd3;
    localparam tmr_addr_t TMR_SNAP_L  = 3'd4;
    localparam tmr_addr_t TMR_SNAP_H  = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    localparam int STAT_TO  = 0;
    localparam int STAT_RUN = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_PL,
        S_WR_PH,
        S_WR_CTRL,
        S_RUN,
        S_RD_ST,
        S_WAIT_ST,
        S_WR_CLR,
        S_WR_SN,
        S_RD_SL,
        S_WAIT_SL,
        S_RD_SH,
        S_WAIT_SH,
        S_WR_STOP,
        S_WR_CLR2
    } host_state_t;

endpackage

// File: rtl/soc_timer_avm_port.sv
// Single-access Avalon-MM issue port: a request appears on the bus the next cycle for one cycle;
// read data is flagged READ_LATENCY cycles after the bus read. No waitrequest, accepts a request every cycle.
module soc_timer_avm_port
    import soc_timer_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        req_write,
    input  tmr_addr_t   req_address,
    input  logic [15:0] req_writedata,
    output tmr_addr_t   avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata,
    input  logic [15:0] avm_readdata,
    output logic        rd_done,
    output logic [15:0] rd_data
);

    logic [READ_LATENCY-1:0] rd_pipe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm_address    <= TMR_STATUS;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
            rd_pipe        <= '0;
        end else begin
            avm_chipselect <= req;
            avm_write_n    <= ~(req & req_write);
            if (req) begin
                avm_address   <= req_address;
                avm_writedata <= req_write ? req_writedata : 16'd0;
            end
            // Bit k set means a bus read happened k+1 cycles ago.
            rd_pipe <= (rd_pipe << 1) | READ_LATENCY'(avm_chipselect & avm_write_n);
        end
    end

    assign rd_done = rd_pipe[READ_LATENCY-1];
    assign rd_data = avm_readdata;

endmodule

// File: rtl/soc_timer_host.sv
// Hardware host for the SoC interval timer: programs period, runs continuous with IRQ, services
// timeouts into tick/tick_count and takes counter snapshots. Inputs are pulses; no backpressure.
module soc_timer_host
    import soc_timer_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [3:0]  CTRL_RUN     = 4'h7,
    parameter logic [3:0]  CTRL_STOP    = 4'h8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cfg_period,
    input  logic        cfg_start,
    input  logic        cfg_stop,
    input  logic        snap_req,
    input  logic        irq_in,
    output logic [2:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata,
    input  logic [15:0] avm_readdata,
    output logic        tick,
    output logic [31:0] tick_count,
    output logic        snap_valid,
    output logic [31:0] snap_value,
    output logic        busy,
    output logic        start_err
);

    host_state_t state, state_n;
    logic [31:0] period_q;
    logic [15:0] snap_lo;
    logic        snap_pend, snap_pend_n;
    logic        irq_hold;

    logic        req, req_write;
    tmr_addr_t   req_address;
    logic [15:0] req_writedata;
    logic        rd_done;
    logic [15:0] rd_data;

    logic        start_ok, start_rej, tick_en, lo_en, snap_en;

    soc_timer_avm_port #(
        .READ_LATENCY (READ_LATENCY)
    ) u_port (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_write      (req_write),
        .req_address    (req_address),
        .req_writedata  (req_writedata),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .rd_done        (rd_done),
        .rd_data        (rd_data)
    );

    always_comb begin
        state_n       = state;
        snap_pend_n   = snap_pend;
        req           = 1'b0;
        req_write     = 1'b0;
        req_address   = TMR_STATUS;
        req_writedata = 16'd0;
        start_ok      = 1'b0;
        start_rej     = 1'b0;
        tick_en       = 1'b0;
        lo_en         = 1'b0;
        snap_en       = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    if (cfg_period != 32'd0) begin
                        start_ok = 1'b1;
                        state_n  = S_WR_PL;
                    end else begin
                        start_rej = 1'b1;
                    end
                end
            end
            S_WR_PL: begin
                req           = 1'b1;
                req_write     = 1'b1;
                req_address   = TMR_PER_L;
                req_writedata = period_q[15:0];
                state_n       = S_WR_PH;
            end
            S_WR_PH: begin
                req           = 1'b1;
                req_write     = 1'b1;
                req_address   = TMR_PER_H;
                req_writedata = period_q[31:16];
                state_n       = S_WR_CTRL;
            end
            S_WR_CTRL: begin
                req           = 1'b1;
                req_write     = 1'b1;
                req_address   = TMR_CONTROL;
                req_writedata = {12'd0, CTRL_RUN};
                state_n       = S_RUN;
            end
            S_RUN: begin
                // irq_hold masks the stale irq level for the cycle the clear is still in flight.
                if (cfg_stop)
                    state_n = S_WR_STOP;
                else if (irq_in && !irq_hold)
                    state_n = S_RD_ST;
                else if (snap_pend || snap_req)
                    state_n = S_WR_SN;
            end
            S_RD_ST: begin
                req         = 1'b1;
                req_address = TMR_STATUS;
                state_n     = S_WAIT_ST;
            end
            S_WAIT_ST: begin
                if (rd_done)
                    state_n = rd_data[STAT_TO] ? S_WR_CLR : S_RUN;
            end
            S_WR_CLR: begin
                req         = 1'b1;
                req_write   = 1'b1;
                req_address = TMR_STATUS;
                tick_en     = 1'b1;
                state_n     = S_RUN;
            end
            S_WR_SN: begin
                req         = 1'b1;
                req_write   = 1'b1;
                req_address = TMR_SNAP_L;
                state_n     = S_RD_SL;
            end
            S_RD_SL: begin
                req         = 1'b1;
                req_address = TMR_SNAP_L;
                state_n     = S_WAIT_SL;
            end
            S_WAIT_SL: begin
                if (rd_done) begin
                    lo_en   = 1'b1;
                    state_n = S_RD_SH;
                end
            end
            S_RD_SH: begin
                req         = 1'b1;
                req_address = TMR_SNAP_H;
                state_n     = S_WAIT_SH;
            end
            S_WAIT_SH: begin
                if (rd_done) begin
                    snap_en     = 1'b1;
                    snap_pend_n = 1'b0;
                    state_n     = S_RUN;
                end
            end
            S_WR_STOP: begin
                req           = 1'b1;
                req_write     = 1'b1;
                req_address   = TMR_CONTROL;
                req_writedata = {12'd0, CTRL_STOP};
                state_n       = S_WR_CLR2;
            end
            S_WR_CLR2: begin
                req         = 1'b1;
                req_write   = 1'b1;
                req_address = TMR_STATUS;
                state_n     = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // A request that cannot be served right now is remembered until RUN resumes.
        if (snap_req && !(state == S_RUN && state_n == S_WR_SN))
            snap_pend_n = 1'b1;
        if (state == S_IDLE || state_n == S_IDLE)
            snap_pend_n = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            period_q   <= '0;
            snap_lo    <= '0;
            snap_pend  <= 1'b0;
            irq_hold   <= 1'b0;
            tick       <= 1'b0;
            tick_count <= '0;
            snap_valid <= 1'b0;
            snap_value <= '0;
            start_err  <= 1'b0;
        end else begin
            state      <= state_n;
            snap_pend  <= snap_pend_n;
            irq_hold   <= (state == S_WR_CLR);
            tick       <= tick_en;
            snap_valid <= snap_en;
            start_err  <= start_rej;
            if (start_ok) begin
                period_q   <= cfg_period;
                tick_count <= '0;
            end else if (tick_en) begin
                tick_count <= tick_count + 32'd1;
            end
            if (lo_en)
                snap_lo <= rd_data;
            if (snap_en)
                snap_value <= {rd_data, snap_lo};
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_soc_timer_host.sv
// Directed bench for soc_timer_host against a behavioural interval-timer slave with a bus monitor.
module tb_soc_timer_host;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cfg_period = '0;
    logic        cfg_start = 1'b0;
    logic        cfg_stop = 1'b0;
    logic        snap_req = 1'b0;
    logic        force_irq = 1'b0;
    logic        irq_in;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata;
    logic        tick;
    logic [31:0] tick_count;
    logic        snap_valid;
    logic [31:0] snap_value;
    logic        busy;
    logic        start_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    soc_timer_host dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_period     (cfg_period),
        .cfg_start      (cfg_start),
        .cfg_stop       (cfg_stop),
        .snap_req       (snap_req),
        .irq_in         (irq_in),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .tick           (tick),
        .tick_count     (tick_count),
        .snap_valid     (snap_valid),
        .snap_value     (snap_value),
        .busy           (busy),
        .start_err      (start_err)
    );

    // Behavioural interval-timer slave: counts down, TO on zero, reload, registered readdata.
    logic [31:0] s_per, s_cnt, s_snap;
    logic        s_run, s_cont, s_ito, s_to;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_per <= '0; s_cnt <= '0; s_snap <= '0;
            s_run <= 1'b0; s_cont <= 1'b0; s_ito <= 1'b0; s_to <= 1'b0;
            avm_readdata <= '0;
        end else begin
            if (s_run) begin
                if (s_cnt == 32'd0) begin
                    s_to  <= 1'b1;
                    s_cnt <= s_per;
                    if (!s_cont) s_run <= 1'b0;
                end else begin
                    s_cnt <= s_cnt - 32'd1;
                end
            end
            if (avm_chipselect && !avm_write_n) begin
                case (avm_address)
                    3'd0: s_to <= 1'b0;
                    3'd1: begin
                        s_ito  <= avm_writedata[0];
                        s_cont <= avm_writedata[1];
                        if (avm_writedata[2]) s_run <= 1'b1;
                        if (avm_writedata[3]) s_run <= 1'b0;
                    end
                    3'd2: begin
                        s_per[15:0] <= avm_writedata;
                        s_cnt <= {s_per[31:16], avm_writedata};
                        s_run <= 1'b0;
                    end
                    3'd3: begin
                        s_per[31:16] <= avm_writedata;
                        s_cnt <= {avm_writedata, s_per[15:0]};
                        s_run <= 1'b0;
                    end
                    3'd4, 3'd5: s_snap <= s_cnt;
                    default: ;
                endcase
            end
            if (avm_chipselect && avm_write_n) begin
                case (avm_address)
                    3'd0: avm_readdata <= {14'd0, s_run, s_to};
                    3'd2: avm_readdata <= s_per[15:0];
                    3'd3: avm_readdata <= s_per[31:16];
                    3'd4: avm_readdata <= s_snap[15:0];
                    3'd5: avm_readdata <= s_snap[31:16];
                    default: avm_readdata <= 16'd0;
                endcase
            end
        end
    end

    assign irq_in = (s_to & s_ito) | force_irq;

    // Bus / output monitors
    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [15:0] data;
        int          cyc;
    } bus_t;

    bus_t bus_q[$];
    int   tick_q[$];
    int   se_cnt = 0;
    int   sv_cnt = 0;
    int   busy_cnt = 0;

    always @(negedge clk) begin
        if (avm_chipselect) begin
            bus_t b;
            b.wr   = !avm_write_n;
            b.addr = avm_address;
            b.data = avm_write_n ? 16'd0 : avm_writedata;
            b.cyc  = cyc;
            bus_q.push_back(b);
        end
        if (tick)       tick_q.push_back(cyc);
        if (start_err)  se_cnt++;
        if (snap_valid) sv_cnt++;
        if (busy)       busy_cnt++;
    end

    function automatic logic [31:0] bus_word(input int i);
        if (i < bus_q.size())
            return {12'd0, bus_q[i].wr, bus_q[i].addr, bus_q[i].data};
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int bus_cyc(input int i);
        if (i < bus_q.size()) return bus_q[i].cyc;
        return -1;
    endfunction

    function automatic logic [31:0] bw(input bit wr, input logic [2:0] a, input logic [15:0] d);
        return {12'd0, wr, a, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nstep(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_ticks(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (tick_q.size() < n && k < budget) begin
            nstep(1);
            k++;
        end
        chk(tag, 32'(tick_q.size() >= n), 32'd1);
    endtask

    task automatic pulse_start(input logic [31:0] per);
        cfg_period = per;
        cfg_start  = 1'b1;
        nstep(1);
        cfg_start  = 1'b0;
    endtask

    initial begin
        int k, w, r, tc;
        logic [31:0] exp_snap;

        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, w, r, wait_n;
        logic [31:0] exp_snap;

        // Reset state
        nstep(3);
        chk("rst_bus", {12'd0, avm_chipselect, avm_write_n, avm_address, avm_writedata},
            {12'd0, 1'b0, 1'b1, 3'd0, 16'd0});
        chk("rst_flags", {27'd0, tick, snap_valid, busy, start_err, 1'b0}, 32'd0);
        chk("rst_count", tick_count, 32'd0);
        chk("rst_snap", snap_value, 32'd0);
        reset_n = 1'b1;
        nstep(2);

        // 1: period 99, start sequence and 5 ticks 100 cycles apart
        bus_q.delete(); tick_q.delete();
        pulse_start(32'd99);
        nstep(3);
        chk("t1_nbus", bus_q.size(), 32'd3);
        chk("t1_wr_pl", bus_word(0), bw(1'b1, 3'd2, 16'h0063));
        chk("t1_wr_ph", bus_word(1), bw(1'b1, 3'd3, 16'h0000));
        chk("t1_wr_ctrl", bus_word(2), bw(1'b1, 3'd1, 16'h0007));
        chk("t1_consec", 32'(bus_cyc(2) - bus_cyc(0)), 32'd2);
        k = bus_cyc(2);
        wait_ticks(5, 700, "t1_tick_timeout");
        chk("t1_first_tick", 32'((tick_q.size() > 0) ? tick_q[0] - k : -1), 32'd106);
        for (int i = 1; i < 5; i++)
            chk("t1_spacing", 32'((tick_q.size() > i) ? tick_q[i] - tick_q[i-1] : -1), 32'd100);
        chk("t1_count5", tick_count, 32'd5);
        chk("t1_busy", 32'(busy), 32'd1);

        // 3: cfg_stop in the same cycle irq_in rises
        wait_n = 0;
        while (!(s_cnt == 32'd0 && s_run) && wait_n < 200) begin
            nstep(1);
            wait_n++;
        end
        chk("t3_find_timeout", 32'(wait_n < 200), 32'd1);
        nstep(1);
        chk("t3_irq_high", 32'(irq_in), 32'd1);
        bus_q.delete(); tick_q.delete();
        cfg_stop = 1'b1;
        nstep(1);
        cfg_stop = 1'b0;
        nstep(4);
        chk("t3_nbus", bus_q.size(), 32'd2);
        chk("t3_wr_stop", bus_word(0), bw(1'b1, 3'd1, 16'h0008));
        chk("t3_wr_clr2", bus_word(1), bw(1'b1, 3'd0, 16'h0000));
        chk("t3_no_tick", tick_q.size(), 32'd0);
        chk("t3_count_hold", tick_count, 32'd5);
        chk("t3_idle", 32'(busy), 32'd0);
        chk("t3_to_cleared", 32'(s_to), 32'd0);

        // 2: zero period rejected; snap_req in IDLE dropped
        bus_q.delete();
        se_cnt = 0; busy_cnt = 0;
        pulse_start(32'd0);
        snap_req = 1'b1;
        nstep(1);
        snap_req = 1'b0;
        nstep(4);
        chk("t2_start_err", se_cnt, 32'd1);
        chk("t2_busy_never", busy_cnt, 32'd0);
        chk("t2_no_bus", bus_q.size(), 32'd0);

        // 4: snapshot mid-run, period 0x186A0
        bus_q.delete(); tick_q.delete();
        pulse_start(32'h0001_86A0);
        nstep(10);
        chk("t4_only_start_seq", bus_q.size(), 32'd3);
        chk("t4_wr_pl", bus_word(0), bw(1'b1, 3'd2, 16'h86A0));
        chk("t4_wr_ph", bus_word(1), bw(1'b1, 3'd3, 16'h0001));
        k = bus_cyc(2);
        nstep(10);
        bus_q.delete();
        sv_cnt = 0;
        r = cyc;
        snap_req = 1'b1;
        nstep(1);
        snap_req = 1'b0;
        wait_n = 0;
        while (sv_cnt < 1 && wait_n < 40) begin
            nstep(1);
            wait_n++;
        end
        chk("t4_snap_timeout", 32'(sv_cnt >= 1), 32'd1);
        w = bus_cyc(0);
        chk("t4_wr_sn", bus_word(0), bw(1'b1, 3'd4, 16'h0000));
        chk("t4_wr_sn_cyc", 32'(w - r), 32'd2);
        chk("t4_rd_sl", bus_word(1), bw(1'b0, 3'd4, 16'h0000));
        chk("t4_rd_sh", bus_word(2), bw(1'b0, 3'd5, 16'h0000));
        exp_snap = 32'd100000 - 32'(w - k - 1);
        chk("t4_snap_value", snap_value, exp_snap);
        chk("t4_snap_hi", {16'd0, snap_value[31:16]}, 32'd1);
        nstep(3);
        chk("t4_snap_once", sv_cnt, 32'd1);

        // 5: spurious irq, status read only
        bus_q.delete(); tick_q.delete();
        force_irq = 1'b1;
        nstep(1);
        force_irq = 1'b0;
        nstep(8);
        chk("t5_nbus", bus_q.size(), 32'd1);
        chk("t5_rd_st", bus_word(0), bw(1'b0, 3'd0, 16'h0000));
        chk("t5_no_tick", tick_q.size(), 32'd0);
        chk("t5_count", tick_count, 32'd0);
        cfg_stop = 1'b1;
        nstep(1);
        cfg_stop = 1'b0;
        nstep(4);
        chk("t5_stopped", 32'(busy), 32'd0);

        // 6: asynchronous reset during WR_PH, then restart with period 9
        pulse_start(32'h0001_2345);
        nstep(1);
        chk("t6_mid_seq", {30'd0, busy, avm_chipselect}, 32'd3);
        #1 reset_n = 1'b0;
        #1;
        bus_q.delete();
        chk("t6_rst_bus", {12'd0, avm_chipselect, avm_write_n, avm_address, avm_writedata},
            {12'd0, 1'b0, 1'b1, 3'd0, 16'd0});
        chk("t6_rst_flags", {28'd0, tick, snap_valid, busy, start_err}, 32'd0);
        chk("t6_rst_snap", snap_value, 32'd0);
        nstep(2);
        reset_n = 1'b1;
        nstep(3);
        chk("t6_no_bus", bus_q.size(), 32'd0);
        tick_q.delete();
        pulse_start(32'd9);
        nstep(3);
        k = bus_cyc(2);
        chk("t6_wr_ctrl", bus_word(2), bw(1'b1, 3'd1, 16'h0007));
        wait_ticks(3, 200, "t6_tick_timeout");
        chk("t6_first_tick", 32'((tick_q.size() > 0) ? tick_q[0] - k : -1), 32'd16);
        chk("t6_spacing1", 32'((tick_q.size() > 1) ? tick_q[1] - tick_q[0] : -1), 32'd10);
        chk("t6_spacing2", 32'((tick_q.size() > 2) ? tick_q[2] - tick_q[1] : -1), 32'd10);
        chk("t6_count3", tick_count, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
